// File: rtl/lcd_st_timing_adapter.sv
// -----------------------------------------------------------------------------
// lcd_st_timing_adapter
//
// Avalon-ST timing adapter placed between an LCD-path source (command/pixel
// generator) and the LCD master. It turns a source with ready latency
// IN_READY_LATENCY (0..3) into a ready-latency-0 sink. Beats that are already
// in flight when credit runs out are absorbed in a small circular FIFO, so
// backpressure never loses data from a compliant source. With HAS_IN_READY=0
// the source cannot be stalled: beats arriving at a full FIFO are dropped and
// recorded in a sticky overflow flag and a saturating drop counter.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   in_valid    in   upstream beat valid
//   in_data     in   upstream payload [DATA_WIDTH]
//   in_ready    out  credit to upstream (upstream sees it IN_READY_LATENCY later)
//   out_valid   out  downstream beat valid (FIFO not empty)
//   out_data    out  downstream payload, FIFO head (first-word fall-through)
//   out_ready   in   downstream ready, latency 0
//   overflow    out  sticky: at least one beat dropped since reset
//   drop_count  out  number of dropped beats, saturates at 255
//   fill_level  out  current FIFO occupancy
// -----------------------------------------------------------------------------
module lcd_st_timing_adapter #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int IN_READY_LATENCY = 0,
  parameter bit HAS_IN_READY     = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  input  logic                              out_ready,
  output logic                              overflow,
  output logic [7:0]                        drop_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Keep the credit history at least one bit wide so latency 0 still elaborates.
  localparam int HW = (IN_READY_LATENCY > 0) ? IN_READY_LATENCY : 1;
  localparam int SW = CW + 2;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [HW-1:0]         hist;
  logic [1:0]            pending;
  logic                  full;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  drop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits granted in the last IN_READY_LATENCY cycles whose beats may still
  // arrive; they must be reserved in the FIFO before granting new credit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned and no latch is inferred.
    pending = '0;
    for (int i = 0; i < IN_READY_LATENCY; i++) begin
      pending = pending + 2'(hist[i]);
    end
  end

  // Depends on registers only, so there is no combinational path from
  // out_ready or in_valid to in_ready.
  assign in_ready = (SW'(count) + SW'(pending)) < SW'(FIFO_DEPTH);

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign fill_level = count;
  assign pop       = out_valid && out_ready;

  always_comb begin
    if (!HAS_IN_READY) begin
      push_req = in_valid;
    end else if (IN_READY_LATENCY == 0) begin
      push_req = in_valid && in_ready;
    end else begin
      // The source only asserts valid where credit was granted L cycles ago.
      push_req = in_valid;
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = push_req && (!full || pop);
  assign drop = push_req && !push;

  // NOTE: the payload array has no reset; out_data is only meaningful while
  // out_valid is high, and leaving it unreset keeps it in plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hist       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Newest in_ready enters at bit 0; the oldest falls off the top.
      hist <= HW'({hist, in_ready});
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_st_timing_adapter.sv
// -----------------------------------------------------------------------------
// tb_lcd_st_timing_adapter
//
// Three adapters share clock and reset:
//   g[0]: IN_READY_LATENCY=0, HAS_IN_READY=1
//   g[1]: IN_READY_LATENCY=2, HAS_IN_READY=1 (source honours the latency)
//   g[2]: IN_READY_LATENCY=0, HAS_IN_READY=0 (source cannot be stalled)
// Each instance has a queue-based model of the adapter behaviour; every
// negative edge its outputs are compared with the model. Directed scenarios
// add literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_lcd_st_timing_adapter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [7:0] in_data [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int LAT = (k == 1) ? 2 : 0;
    localparam bit HIR = (k == 2) ? 1'b0 : 1'b1;

    logic       rdy;
    logic       ov;
    logic [7:0] od;
    logic       ovf;
    logic [7:0] dc;
    logic [2:0] fl;

    lcd_st_timing_adapter #(
      .DATA_WIDTH      (8),
      .FIFO_DEPTH      (4),
      .IN_READY_LATENCY(LAT),
      .HAS_IN_READY    (HIR)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[k]),
      .in_data    (in_data[k]),
      .in_ready   (rdy),
      .out_valid  (ov),
      .out_data   (od),
      .out_ready  (out_ready[k]),
      .overflow   (ovf),
      .drop_count (dc),
      .fill_level (fl)
    );

    // Model state: buffered beats in order, the credit values granted over
    // the last LAT cycles (oldest first), and the drop bookkeeping.
    logic [7:0] mq [$];
    bit         hist_q [$];
    bit         m_ovf;
    int         m_drops;
    bit         started;
    bit         allowed;   // a compliant source may assert valid this cycle
    logic [7:0] got [$];   // beats actually handed downstream by the DUT

    function automatic bit model_ready();
      int pend = 0;
      foreach (hist_q[i]) pend += int'(hist_q[i]);
      return (mq.size() + pend) < 4;
    endfunction

    always @(posedge clk) begin
      if (!reset && ov && out_ready[k]) got.push_back(od);
    end

    always @(posedge clk) begin
      if (reset) begin
        mq.delete();
        hist_q.delete();
        for (int i = 0; i < LAT; i++) hist_q.push_back(1'b0);
        m_ovf   = 1'b0;
        m_drops = 0;
        started = 1'b1;
      end else begin
        bit r;
        bit pop;
        bit preq;
        r    = model_ready();
        pop  = (mq.size() != 0) && out_ready[k];
        preq = in_valid[k] && (!HIR || LAT != 0 || r);
        if (pop) void'(mq.pop_front());
        if (preq) begin
          if (mq.size() < 4) mq.push_back(in_data[k]);
          else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
          end
        end
        if (LAT != 0) begin
          hist_q.push_back(r);
          void'(hist_q.pop_front());
        end
      end
      if (LAT == 0) allowed = 1'b1;
      else allowed = (hist_q.size() != 0) && hist_q[0];
    end

    always @(negedge clk) begin
      if (started) begin
        check($sformatf("m%0d_out_valid", k), 32'(ov), 32'(mq.size() != 0));
        if (mq.size() != 0) check($sformatf("m%0d_out_data", k), 32'(od), 32'(mq[0]));
        check($sformatf("m%0d_in_ready", k), 32'(rdy), 32'(model_ready()));
        check($sformatf("m%0d_fill_level", k), 32'(fl), 32'(mq.size()));
        check($sformatf("m%0d_overflow", k), 32'(ovf), 32'(m_ovf));
        check($sformatf("m%0d_drop_count", k), 32'(dc), 32'(m_drops));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int peak;
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;

    // Reset / idle
    tick(2);
    check("rst_out_valid", 32'(g[0].ov), 0);
    check("rst_in_ready", 32'(g[1].rdy), 1);
    check("rst_fill_level", 32'(g[2].fl), 0);
    check("rst_overflow", 32'(g[2].ovf), 0);
    check("rst_drop_count", 32'(g[2].dc), 0);
    reset = 1'b0;
    tick(4);

    // Pass-through, latency 0: 0x01..0x10 with out_ready held high
    out_ready[0] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(i);
      tick();
      check("pt_in_ready", 32'(g[0].rdy), 1);
      check("pt_head", 32'(g[0].od), 32'(i));
    end
    in_valid[0] = 1'b0;
    tick(3);
    check("pt_count", 32'(g[0].got.size()), 16);
    for (int i = 0; i < 16; i++) check("pt_order", 32'(g[0].got[i]), 32'(i + 1));

    // Backpressure, latency 2: compliant source, out_ready low for 10 cycles
    n = 0;
    peak = 0;
    for (int c = 0; c < 300 && g[1].got.size() < 16; c++) begin
      out_ready[1] = (c >= 10);
      if (n < 16 && g[1].allowed) begin
        in_valid[1] = 1'b1;
        in_data[1]  = 8'(8'hA0 + n);
        n++;
      end else begin
        in_valid[1] = 1'b0;
      end
      tick();
      if (int'(g[1].fl) > peak) peak = int'(g[1].fl);
    end
    in_valid[1] = 1'b0;
    check("bp_delivered", 32'(g[1].got.size()), 16);
    check("bp_peak_fill", 32'(peak), 4);
    check("bp_drop_count", 32'(g[1].dc), 0);
    for (int i = 0; i < 16; i++) check("bp_order", 32'(g[1].got[i]), 32'(8'hA0 + i));

    // Full with simultaneous push and pop, no-backpressure mode
    g[2].got.delete();
    out_ready[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = 8'(8'h30 + i);
      tick();
    end
    check("fp_filled", 32'(g[2].fl), 4);
    out_ready[2] = 1'b1;
    for (int i = 4; i < 9; i++) begin
      in_data[2] = 8'(8'h30 + i);
      tick();
      check("fp_fill_steady", 32'(g[2].fl), 4);
    end
    in_valid[2] = 1'b0;
    tick(6);
    check("fp_drop_count", 32'(g[2].dc), 0);
    check("fp_delivered", 32'(g[2].got.size()), 9);
    for (int i = 0; i < 9; i++) check("fp_order", 32'(g[2].got[i]), 32'(8'h30 + i));

    // Overflow: 300 beats into a stalled FIFO
    g[2].got.delete();
    out_ready[2] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = 8'(i);
      tick();
    end
    in_valid[2] = 1'b0;
    tick();
    check("ov_fill_level", 32'(g[2].fl), 4);
    check("ov_overflow", 32'(g[2].ovf), 1);
    check("ov_drop_count", 32'(g[2].dc), 255);
    check("ov_head", 32'(g[2].od), 0);
    out_ready[2] = 1'b1;
    tick(5);
    check("ov_retained", 32'(g[2].got.size()), 4);
    for (int i = 0; i < 4; i++) check("ov_order", 32'(g[2].got[i]), 32'(i));

    // Reset mid-operation
    out_ready[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = 8'($urandom);
      tick();
    end
    in_valid[2] = 1'b0;
    check("mr_filled", 32'(g[2].fl), 3);
    reset = 1'b1;
    tick();
    check("mr_out_valid", 32'(g[2].ov), 0);
    check("mr_fill_level", 32'(g[2].fl), 0);
    check("mr_overflow", 32'(g[2].ovf), 0);
    reset       = 1'b0;
    in_valid[2] = 1'b1;
    in_data[2]  = 8'h5A;
    tick();
    in_valid[2] = 1'b0;
    check("mr_new_valid", 32'(g[2].ov), 1);
    check("mr_new_data", 32'(g[2].od), 32'h5A);
    out_ready[2] = 1'b1;
    tick(2);

    // Randomized traffic on all three instances
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) in_data[k] = 8'($urandom);
      in_valid[0]  = ($urandom_range(0, 3) != 0);
      in_valid[1]  = g[1].allowed && ($urandom_range(0, 3) != 0);
      in_valid[2]  = ($urandom_range(0, 2) != 0);
      out_ready[0] = ($urandom_range(0, 2) != 0);
      out_ready[1] = ($urandom_range(0, 1) != 0);
      out_ready[2] = ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_st_timing_adapter.md
# lcd_st_timing_adapter

Parametrised Avalon-ST timing adapter that sits between an LCD-path source (command/pixel generator) and the LCD master. It converts a source with configurable ready latency (0..3) into a ready-latency-0 sink interface, absorbing in-flight beats in a small FIFO so backpressure never loses data. A no-backpressure mode handles sources with no ready input, dropping beats on overflow and flagging them with a sticky flag and a drop counter.

## Interface
- DATA_WIDTH, 8, payload width in bits (1..64)
- FIFO_DEPTH, 4, buffer entries; power of two, ≥ IN_READY_LATENCY+1 (≥ IN_READY_LATENCY+2 for full throughput)
- IN_READY_LATENCY, 0, upstream ready latency (0..3)
- HAS_IN_READY, 1, 1 = upstream honours in_ready; 0 = upstream cannot be backpressured, in_ready informative only
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_data  in  DATA_WIDTH  upstream payload
- in_ready  out  1  credit to upstream, latency IN_READY_LATENCY
- out_valid  out  1  downstream beat valid
- out_data  out  DATA_WIDTH  downstream payload (FIFO head)
- out_ready  in  1  downstream ready, latency 0
- overflow  out  1  sticky: at least one beat dropped since reset
- drop_count  out  8  dropped beats, saturates at 255
- fill_level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy

## Operation
- Storage: circular FIFO, wr_ptr/rd_ptr of clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; count register separate (0..FIFO_DEPTH).
- Credit: hist = shift register of the last IN_READY_LATENCY values of in_ready; pending = popcount(hist) (0 when latency is 0).
- in_ready = (count + pending) < FIFO_DEPTH, combinational from registers only (no dependence on out_ready, in_valid).
- Push request: IN_READY_LATENCY=0 → in_valid && in_ready; otherwise → in_valid (upstream guarantees it only drives valid where ready was high L cycles earlier).
- HAS_IN_READY=0: push request = in_valid every cycle.
- Pop = out_valid && out_ready. out_valid = (count != 0); out_data = mem[rd_ptr] (first-word fall-through).
- Push accepted if count < FIFO_DEPTH, or count == FIFO_DEPTH and pop in same cycle. Otherwise beat dropped: overflow ← 1, drop_count += 1 (saturating). Memory and pointers unchanged on drop.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- With HAS_IN_READY=1 and a compliant source, drops never occur; any drop indicates a protocol violation upstream.
- fill_level = count.

## Timing
- Reset (sync, on clk edge with reset=1): count=0, pointers=0, hist=0, overflow=0, drop_count=0 → out_valid=0, fill_level=0, in_ready=1. Memory contents not reset; out_data is don't-care while out_valid=0. Reset mid-stream discards all buffered beats; no beat is emitted in the cycle after reset.
- Latency in→out: beat accepted at edge t appears on out_data/out_valid in cycle t+1 (no same-cycle bypass).
- Throughput: one beat/cycle sustained when out_ready=1 and FIFO_DEPTH ≥ IN_READY_LATENCY+2.
- in_ready at cycle t reflects state after edge t; a pop in cycle t frees credit from cycle t+1.
- Ordering: strict FIFO; payload bit-exact.
- overflow/drop_count update at the edge closing the drop cycle.

## Test plan
- Reset/idle: assert reset 2 cycles → out_valid=0, in_ready=1, fill_level=0, overflow=0, drop_count=0.
- Pass-through, L=0, DEPTH=4: stream 0x01..0x10 with out_ready=1 → each beat out one cycle later, in order, in_ready constant 1, no gaps.
- Backpressure, L=2, DEPTH=4: compliant source sends 0xA0..0xAF, out_ready=0 for 10 cycles → in_ready drops once count+pending=4, fill_level peaks 4, then all 16 beats delivered in order after release, drop_count=0.
- Full with simultaneous push/pop, HAS_IN_READY=0, DEPTH=4: fill to 4, then in_valid and out_ready both 1 for 5 cycles → fill_level stays 4, no drops, order preserved.
- Overflow, HAS_IN_READY=0, DEPTH=4, out_ready=0: send 300 beats → fill_level=4, first 4 beats retained, overflow=1, drop_count=255 (saturated).
- Reset mid-operation: fill to 3, assert reset 1 cycle → next cycle out_valid=0, fill_level=0, overflow=0; new beat 0x5A appears one cycle after acceptance.
